// File: rtl/neural_frame_assembler.sv
// neural_frame_assembler: rebuilds parallel frames of NUM_CHANNELS samples from the
// serialized (data, channel ID, valid) stream and hands each whole frame downstream
// over a valid/ready handshake, together with the mask of channels actually received.
module neural_frame_assembler #(
    parameter int NUM_CHANNELS   = 16,
    parameter int DATA_WIDTH     = 16,
    parameter int CH_ID_WIDTH    = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int DROP_CNT_WIDTH = 8
) (
    input  logic                               sys_clk,
    input  logic                               rst,
    input  logic [NUM_CHANNELS-1:0]            channel_mask,
    input  logic [DATA_WIDTH-1:0]              adc_data_in,
    input  logic [CH_ID_WIDTH-1:0]             adc_channel_in,
    input  logic                               adc_valid_in,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0] frame_data_out,
    output logic [NUM_CHANNELS-1:0]            frame_mask_out,
    output logic                               frame_partial_out,
    output logic [7:0]                         frame_seq_out,
    output logic                               frame_valid_out,
    input  logic                               frame_ready_in,
    output logic                               stray_err,
    output logic [DROP_CNT_WIDTH-1:0]          drop_count
);
    localparam int TO_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

    state_t                             state, state_next;
    logic [NUM_CHANNELS*DATA_WIDTH-1:0] slots_next, start_slots;
    logic [NUM_CHANNELS-1:0]            rx_next, active_mask, active_next;
    logic [NUM_CHANNELS-1:0]            id_bit, pend_bit, start_rx;
    logic                               partial_next, stray_next, start_stray;
    logic [7:0]                         seq_next;
    logic [DROP_CNT_WIDTH-1:0]          drop_next;
    logic [TO_WIDTH-1:0]                timeout_cnt, timeout_next;
    logic                               pend_valid, pend_valid_next;
    logic [DATA_WIDTH-1:0]              pend_data, pend_data_next;
    logic [CH_ID_WIDTH-1:0]             pend_ch, pend_ch_next;
    logic                               id_in_range, in_new_mask, in_active_mask;
    logic                               transfer, do_start;

    assign transfer = frame_valid_out && frame_ready_in;

    // Decode the incoming channel ID to a one-hot bit and test it against both masks.
    always_comb begin
        id_in_range    = (int'(adc_channel_in) < NUM_CHANNELS);
        id_bit         = id_in_range ? (NUM_CHANNELS'(1) << adc_channel_in) : '0;
        pend_bit       = NUM_CHANNELS'(1) << pend_ch;
        in_new_mask    = |(id_bit & channel_mask);
        in_active_mask = |(id_bit & active_mask);
    end

    // First contents of a new frame: held-over duplicate plus any same-cycle sample.
    always_comb begin
        start_slots = '0;
        start_rx    = '0;
        start_stray = 1'b0;
        if (pend_valid && |(pend_bit & channel_mask)) begin
            start_slots[int'(pend_ch)*DATA_WIDTH +: DATA_WIDTH] = pend_data;
            start_rx = pend_bit;
        end
        if (adc_valid_in) begin
            if (in_new_mask) begin
                start_slots[int'(adc_channel_in)*DATA_WIDTH +: DATA_WIDTH] = adc_data_in;
                start_rx = start_rx | id_bit;
            end else begin
                start_stray = 1'b1;
            end
        end
    end

    // Next-state and next-frame logic for the IDLE / COLLECT / HOLD sequencer.
    always_comb begin
        state_next      = state;
        slots_next      = frame_data_out;
        rx_next         = frame_mask_out;
        active_next     = active_mask;
        partial_next    = frame_partial_out;
        seq_next        = frame_seq_out;
        stray_next      = 1'b0;
        drop_next       = drop_count;
        timeout_next    = timeout_cnt;
        pend_valid_next = pend_valid;
        pend_data_next  = pend_data;
        pend_ch_next    = pend_ch;
        do_start        = 1'b0;
        case (state)
            IDLE: begin
                do_start = 1'b1;
            end
            COLLECT: begin
                if (adc_valid_in && in_active_mask && !(|(id_bit & frame_mask_out))) begin
                    slots_next[int'(adc_channel_in)*DATA_WIDTH +: DATA_WIDTH] = adc_data_in;
                    rx_next      = frame_mask_out | id_bit;
                    timeout_next = '0;
                    if ((frame_mask_out | id_bit) == active_mask) begin
                        partial_next = 1'b0;
                        state_next   = HOLD;
                    end
                end else if (adc_valid_in && in_active_mask) begin
                    pend_valid_next = 1'b1;
                    pend_data_next  = adc_data_in;
                    pend_ch_next    = adc_channel_in;
                    partial_next    = 1'b1;
                    state_next      = HOLD;
                end else begin
                    stray_next = adc_valid_in;
                    if (timeout_cnt == TO_WIDTH'(TIMEOUT_CYCLES - 1)) begin
                        partial_next = 1'b1;
                        state_next   = HOLD;
                    end else begin
                        timeout_next = timeout_cnt + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (transfer) begin
                    seq_next        = frame_seq_out + 8'd1;
                    pend_valid_next = 1'b0;
                    state_next      = IDLE;
                    do_start        = 1'b1;
                end else if (adc_valid_in && (drop_count != '1)) begin
                    drop_next = drop_count + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        if (do_start) begin
            stray_next = start_stray;
            if (start_rx != '0) begin
                active_next  = channel_mask;
                slots_next   = start_slots;
                rx_next      = start_rx;
                partial_next = 1'b0;
                timeout_next = '0;
                state_next   = (start_rx == channel_mask) ? HOLD : COLLECT;
            end
        end
    end

    // State, frame and bookkeeping registers; reset discards any frame in progress.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state             <= IDLE;
            frame_data_out    <= '0;
            frame_mask_out    <= '0;
            frame_partial_out <= 1'b0;
            frame_seq_out     <= 8'd0;
            frame_valid_out   <= 1'b0;
            stray_err         <= 1'b0;
            drop_count        <= '0;
            active_mask       <= '0;
            timeout_cnt       <= '0;
            pend_valid        <= 1'b0;
            pend_data         <= '0;
            pend_ch           <= '0;
        end else begin
            state             <= state_next;
            frame_data_out    <= slots_next;
            frame_mask_out    <= rx_next;
            frame_partial_out <= partial_next;
            frame_seq_out     <= seq_next;
            frame_valid_out   <= (state_next == HOLD);
            stray_err         <= stray_next;
            drop_count        <= drop_next;
            active_mask       <= active_next;
            timeout_cnt       <= timeout_next;
            pend_valid        <= pend_valid_next;
            pend_data         <= pend_data_next;
            pend_ch           <= pend_ch_next;
        end
    end
endmodule

// File: tb/tb_neural_frame_assembler.sv
// Testbench for neural_frame_assembler: directed scenarios plus a randomized sample
// stream compared against a frame-level reference model.
`timescale 1ns/1ps
module tb_neural_frame_assembler;
    localparam int NC  = 16;
    localparam int DW  = 16;
    localparam int CW  = 4;
    localparam int TO  = 64;
    localparam int DCW = 8;

    logic              sys_clk = 1'b0;
    logic              rst;
    logic [NC-1:0]     channel_mask;
    logic [DW-1:0]     adc_data_in;
    logic [CW-1:0]     adc_channel_in;
    logic              adc_valid_in;
    logic [NC*DW-1:0]  frame_data_out;
    logic [NC-1:0]     frame_mask_out;
    logic              frame_partial_out;
    logic [7:0]        frame_seq_out;
    logic              frame_valid_out;
    logic              frame_ready_in;
    logic              stray_err;
    logic [DCW-1:0]    drop_count;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] exp_seq  = 8'd0;

    typedef struct {
        logic [NC*DW-1:0] data;
        logic [NC-1:0]    mask;
        logic             partial;
        logic [7:0]       seq;
    } frame_t;

    frame_t obs_frames[$];
    frame_t mon_f;
    int     obs_strays = 0;

    neural_frame_assembler #(
        .NUM_CHANNELS(NC), .DATA_WIDTH(DW), .CH_ID_WIDTH(CW),
        .TIMEOUT_CYCLES(TO), .DROP_CNT_WIDTH(DCW)
    ) dut (
        .sys_clk(sys_clk), .rst(rst), .channel_mask(channel_mask),
        .adc_data_in(adc_data_in), .adc_channel_in(adc_channel_in), .adc_valid_in(adc_valid_in),
        .frame_data_out(frame_data_out), .frame_mask_out(frame_mask_out),
        .frame_partial_out(frame_partial_out), .frame_seq_out(frame_seq_out),
        .frame_valid_out(frame_valid_out), .frame_ready_in(frame_ready_in),
        .stray_err(stray_err), .drop_count(drop_count)
    );

    always #5 sys_clk = ~sys_clk;

    // Record every handshake transfer and every stray pulse, sampled mid-cycle.
    always @(negedge sys_clk) begin
        if (!rst) begin
            if (frame_valid_out && frame_ready_in) begin
                mon_f.data    = frame_data_out;
                mon_f.mask    = frame_mask_out;
                mon_f.partial = frame_partial_out;
                mon_f.seq     = frame_seq_out;
                obs_frames.push_back(mon_f);
            end
            if (stray_err) obs_strays++;
        end
    end

    // Hard stop in case a scenario wedges.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic send(input int ch, input logic [DW-1:0] d);
        adc_valid_in   = 1'b1;
        adc_channel_in = CW'(ch);
        adc_data_in    = d;
        tick();
        adc_valid_in   = 1'b0;
    endtask

    function automatic logic [DW-1:0] slot_of(input int i);
        return frame_data_out[i*DW +: DW];
    endfunction

    task automatic test_reset();
        rst = 1'b1; channel_mask = '0; adc_valid_in = 1'b0; adc_channel_in = '0;
        adc_data_in = '0; frame_ready_in = 1'b1;
        repeat (3) tick();
        n_checks++; if (frame_valid_out !== 1'b0) $display("[TB] FAIL reset_valid: got %0b expected 0", frame_valid_out); else n_pass++;
        n_checks++; if (frame_mask_out !== '0) $display("[TB] FAIL reset_mask: got %h expected 0", frame_mask_out); else n_pass++;
        n_checks++; if (frame_data_out !== '0) $display("[TB] FAIL reset_data: got %h expected 0", frame_data_out); else n_pass++;
        n_checks++; if (frame_partial_out !== 1'b0) $display("[TB] FAIL reset_partial: got %0b expected 0", frame_partial_out); else n_pass++;
        n_checks++; if (frame_seq_out !== 8'd0) $display("[TB] FAIL reset_seq: got %0d expected 0", frame_seq_out); else n_pass++;
        n_checks++; if (stray_err !== 1'b0) $display("[TB] FAIL reset_stray: got %0b expected 0", stray_err); else n_pass++;
        n_checks++; if (drop_count !== '0) $display("[TB] FAIL reset_drop: got %0d expected 0", drop_count); else n_pass++;
        rst = 1'b0;
        tick();
        n_checks++; if (frame_valid_out !== 1'b0) $display("[TB] FAIL reset_idle_valid: got %0b expected 0", frame_valid_out); else n_pass++;
    endtask

    task automatic test_complete_frame();
        logic [DW-1:0] exp_d;
        channel_mask = 16'h00FF; frame_ready_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(i, DW'(16'h1000 + i));
            if (i < 7) begin
                n_checks++; if (frame_valid_out !== 1'b0) $display("[TB] FAIL complete_early_valid ch%0d: got %0b expected 0", i, frame_valid_out); else n_pass++;
            end
        end
        n_checks++; if (frame_valid_out !== 1'b1) $display("[TB] FAIL complete_valid: got %0b expected 1", frame_valid_out); else n_pass++;
        n_checks++; if (frame_mask_out !== 16'h00FF) $display("[TB] FAIL complete_mask: got %h expected 00ff", frame_mask_out); else n_pass++;
        n_checks++; if (frame_partial_out !== 1'b0) $display("[TB] FAIL complete_partial: got %0b expected 0", frame_partial_out); else n_pass++;
        n_checks++; if (frame_seq_out !== exp_seq) $display("[TB] FAIL complete_seq: got %0d expected %0d", frame_seq_out, exp_seq); else n_pass++;
        for (int i = 0; i < NC; i++) begin
            exp_d = (i < 8) ? DW'(16'h1000 + i) : '0;
            n_checks++; if (slot_of(i) !== exp_d) $display("[TB] FAIL complete_slot%0d: got %h expected %h", i, slot_of(i), exp_d); else n_pass++;
        end
        tick();
        exp_seq++;
        n_checks++; if (frame_valid_out !== 1'b0) $display("[TB] FAIL complete_one_cycle: got %0b expected 0", frame_valid_out); else n_pass++;
        n_checks++; if (frame_seq_out !== exp_seq) $display("[TB] FAIL complete_seq_after: got %0d expected %0d", frame_seq_out, exp_seq); else n_pass++;
    endtask

    task automatic test_timeout();
        int cycles = 0;
        bit seen = 0;
        channel_mask = 16'hFFFF; frame_ready_in = 1'b1;
        for (int i = 0; i < 5; i++) send(i, DW'(16'h2000 + i));
        while (!seen && cycles < 4*TO) begin
            tick();
            cycles++;
            if (frame_valid_out) seen = 1;
        end
        n_checks++; if (seen !== 1'b1) $display("[TB] FAIL timeout_seen: got %0b expected 1", seen); else n_pass++;
        n_checks++; if (cycles != TO) $display("[TB] FAIL timeout_latency: got %0d expected %0d", cycles, TO); else n_pass++;
        n_checks++; if (frame_mask_out !== 16'h001F) $display("[TB] FAIL timeout_mask: got %h expected 001f", frame_mask_out); else n_pass++;
        n_checks++; if (frame_partial_out !== 1'b1) $display("[TB] FAIL timeout_partial: got %0b expected 1", frame_partial_out); else n_pass++;
        n_checks++; if (slot_of(4) !== 16'h2004) $display("[TB] FAIL timeout_slot4: got %h expected 2004", slot_of(4)); else n_pass++;
        n_checks++; if (frame_seq_out !== exp_seq) $display("[TB] FAIL timeout_seq: got %0d expected %0d", frame_seq_out, exp_seq); else n_pass++;
        tick();
        exp_seq++;
        n_checks++; if (frame_valid_out !== 1'b0) $display("[TB] FAIL timeout_release: got %0b expected 0", frame_valid_out); else n_pass++;
    endtask

    task automatic test_duplicate();
        frame_ready_in = 1'b0; channel_mask = 16'h000F;
        send(0, 16'hAAAA);
        send(1, 16'hBBBB);
        n_checks++; if (frame_valid_out !== 1'b0) $display("[TB] FAIL dup_early_valid: got %0b expected 0", frame_valid_out); else n_pass++;
        send(1, 16'hCCCC);
        n_checks++; if (frame_valid_out !== 1'b1) $display("[TB] FAIL dup_close_valid: got %0b expected 1", frame_valid_out); else n_pass++;
        n_checks++; if (frame_mask_out !== 16'h0003) $display("[TB] FAIL dup_mask1: got %h expected 0003", frame_mask_out); else n_pass++;
        n_checks++; if (frame_partial_out !== 1'b1) $display("[TB] FAIL dup_partial1: got %0b expected 1", frame_partial_out); else n_pass++;
        n_checks++; if (slot_of(1) !== 16'hBBBB) $display("[TB] FAIL dup_slot1_first: got %h expected bbbb", slot_of(1)); else n_pass++;
        n_checks++; if (slot_of(0) !== 16'hAAAA) $display("[TB] FAIL dup_slot0_first: got %h expected aaaa", slot_of(0)); else n_pass++;
        frame_ready_in = 1'b1;
        tick();
        exp_seq++;
        n_checks++; if (frame_valid_out !== 1'b0) $display("[TB] FAIL dup_transfer: got %0b expected 0", frame_valid_out); else n_pass++;
        send(2, 16'h2222);
        send(3, 16'h3333);
        n_checks++; if (frame_valid_out !== 1'b0) $display("[TB] FAIL dup_second_early: got %0b expected 0", frame_valid_out); else n_pass++;
        send(0, 16'h0A0A);
        n_checks++; if (frame_valid_out !== 1'b1) $display("[TB] FAIL dup_second_valid: got %0b expected 1", frame_valid_out); else n_pass++;
        n_checks++; if (frame_mask_out !== 16'h000F) $display("[TB] FAIL dup_mask2: got %h expected 000f", frame_mask_out); else n_pass++;
        n_checks++; if (frame_partial_out !== 1'b0) $display("[TB] FAIL dup_partial2: got %0b expected 0", frame_partial_out); else n_pass++;
        n_checks++; if (slot_of(1) !== 16'hCCCC) $display("[TB] FAIL dup_slot1_second: got %h expected cccc", slot_of(1)); else n_pass++;
        n_checks++; if (slot_of(0) !== 16'h0A0A) $display("[TB] FAIL dup_slot0_second: got %h expected 0a0a", slot_of(0)); else n_pass++;
        n_checks++; if (slot_of(3) !== 16'h3333) $display("[TB] FAIL dup_slot3_second: got %h expected 3333", slot_of(3)); else n_pass++;
        n_checks++; if (frame_seq_out !== exp_seq) $display("[TB] FAIL dup_seq2: got %0d expected %0d", frame_seq_out, exp_seq); else n_pass++;
        tick();
        exp_seq++;
    endtask

    task automatic test_backpressure();
        int exp_drops = 0;
        frame_ready_in = 1'b0; channel_mask = 16'h0003;
        send(0, 16'h5A5A);
        send(1, 16'hA5A5);
        n_checks++; if (frame_valid_out !== 1'b1) $display("[TB] FAIL bp_valid: got %0b expected 1", frame_valid_out); else n_pass++;
        n_checks++; if (frame_partial_out !== 1'b0) $display("[TB] FAIL bp_partial: got %0b expected 0", frame_partial_out); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            send($urandom_range(0, NC-1), DW'($urandom));
            exp_drops++;
            n_checks++; if (frame_valid_out !== 1'b1) $display("[TB] FAIL bp_hold_valid%0d: got %0b expected 1", k, frame_valid_out); else n_pass++;
            n_checks++; if (frame_mask_out !== 16'h0003) $display("[TB] FAIL bp_hold_mask%0d: got %h expected 0003", k, frame_mask_out); else n_pass++;
            n_checks++; if (slot_of(0) !== 16'h5A5A || slot_of(1) !== 16'hA5A5) $display("[TB] FAIL bp_hold_data%0d: got %h/%h expected 5a5a/a5a5", k, slot_of(0), slot_of(1)); else n_pass++;
        end
        n_checks++; if (drop_count !== DCW'(exp_drops)) $display("[TB] FAIL bp_drops: got %0d expected %0d", drop_count, exp_drops); else n_pass++;
        frame_ready_in = 1'b1;
        tick();
        exp_seq++;
        n_checks++; if (frame_valid_out !== 1'b0) $display("[TB] FAIL bp_release: got %0b expected 0", frame_valid_out); else n_pass++;
        tick();
        n_checks++; if (frame_valid_out !== 1'b0) $display("[TB] FAIL bp_idle: got %0b expected 0", frame_valid_out); else n_pass++;
        n_checks++; if (frame_seq_out !== exp_seq) $display("[TB] FAIL bp_seq_once: got %0d expected %0d", frame_seq_out, exp_seq); else n_pass++;
        n_checks++; if (drop_count !== DCW'(exp_drops)) $display("[TB] FAIL bp_drops_kept: got %0d expected %0d", drop_count, exp_drops); else n_pass++;
    endtask

    task automatic test_stray();
        frame_ready_in = 1'b1; channel_mask = 16'h0005;
        send(1, 16'h1111);
        n_checks++; if (stray_err !== 1'b1) $display("[TB] FAIL stray_ch1: got %0b expected 1", stray_err); else n_pass++;
        tick();
        n_checks++; if (stray_err !== 1'b0) $display("[TB] FAIL stray_pulse_width: got %0b expected 0", stray_err); else n_pass++;
        send(15, 16'hFFFF);
        n_checks++; if (stray_err !== 1'b1) $display("[TB] FAIL stray_ch15: got %0b expected 1", stray_err); else n_pass++;
        n_checks++; if (frame_valid_out !== 1'b0) $display("[TB] FAIL stray_no_frame: got %0b expected 0", frame_valid_out); else n_pass++;
        send(0, 16'h0F0F);
        n_checks++; if (stray_err !== 1'b0) $display("[TB] FAIL stray_inmask: got %0b expected 0", stray_err); else n_pass++;
        n_checks++; if (frame_valid_out !== 1'b0) $display("[TB] FAIL stray_early_valid: got %0b expected 0", frame_valid_out); else n_pass++;
        send(2, 16'h2F2F);
        n_checks++; if (frame_valid_out !== 1'b1) $display("[TB] FAIL stray_frame_valid: got %0b expected 1", frame_valid_out); else n_pass++;
        n_checks++; if (frame_mask_out !== 16'h0005) $display("[TB] FAIL stray_frame_mask: got %h expected 0005", frame_mask_out); else n_pass++;
        n_checks++; if (slot_of(1) !== 16'h0000) $display("[TB] FAIL stray_slot1: got %h expected 0000", slot_of(1)); else n_pass++;
        n_checks++; if (slot_of(2) !== 16'h2F2F) $display("[TB] FAIL stray_slot2: got %h expected 2f2f", slot_of(2)); else n_pass++;
        tick();
        exp_seq++;
    endtask

    task automatic test_random();
        logic [NC-1:0]    m;
        logic [NC*DW-1:0] cur_d;
        logic [NC-1:0]    cur_rx;
        logic [DW-1:0]    d;
        frame_t           f;
        frame_t           exp_q[$];
        int               exp_strays = 0;
        int               ch;
        int               prev = -1;
        int               n_cmp;
        do m = NC'($urandom); while ($countones(m) < 2 || $countones(m) == NC);
        channel_mask = m; frame_ready_in = 1'b1;
        tick();
        obs_frames.delete();
        obs_strays = 0;
        cur_d = '0; cur_rx = '0;
        for (int n = 0; n < 250; n++) begin
            do begin
                if ($urandom_range(0, 6) == 0) ch = $urandom_range(0, NC-1);
                else do ch = $urandom_range(0, NC-1); while (!m[ch]);
            end while (ch == prev);
            prev = ch;
            d = DW'($urandom);
            if (!m[ch]) begin
                exp_strays++;
            end else if (cur_rx[ch]) begin
                f.data = cur_d; f.mask = cur_rx; f.partial = 1'b1; f.seq = exp_seq;
                exp_q.push_back(f); exp_seq++;
                cur_d = '0; cur_rx = '0;
                cur_d[ch*DW +: DW] = d; cur_rx[ch] = 1'b1;
            end else begin
                cur_d[ch*DW +: DW] = d; cur_rx[ch] = 1'b1;
                if (cur_rx == m) begin
                    f.data = cur_d; f.mask = cur_rx; f.partial = 1'b0; f.seq = exp_seq;
                    exp_q.push_back(f); exp_seq++;
                    cur_d = '0; cur_rx = '0;
                end
            end
            send(ch, d);
            repeat ($urandom_range(0, 2)) tick();
        end
        if (cur_rx != '0) begin
            f.data = cur_d; f.mask = cur_rx; f.partial = 1'b1; f.seq = exp_seq;
            exp_q.push_back(f); exp_seq++;
        end
        repeat (TO + 16) tick();
        n_checks++; if (obs_frames.size() != exp_q.size()) $display("[TB] FAIL rand_frame_count: got %0d expected %0d", obs_frames.size(), exp_q.size()); else n_pass++;
        n_checks++; if (obs_strays != exp_strays) $display("[TB] FAIL rand_strays: got %0d expected %0d", obs_strays, exp_strays); else n_pass++;
        n_cmp = (obs_frames.size() < exp_q.size()) ? obs_frames.size() : exp_q.size();
        for (int i = 0; i < n_cmp; i++) begin
            n_checks++; if (obs_frames[i].mask !== exp_q[i].mask) $display("[TB] FAIL rand_mask%0d: got %h expected %h", i, obs_frames[i].mask, exp_q[i].mask); else n_pass++;
            n_checks++; if (obs_frames[i].partial !== exp_q[i].partial) $display("[TB] FAIL rand_partial%0d: got %0b expected %0b", i, obs_frames[i].partial, exp_q[i].partial); else n_pass++;
            n_checks++; if (obs_frames[i].seq !== exp_q[i].seq) $display("[TB] FAIL rand_seq%0d: got %0d expected %0d", i, obs_frames[i].seq, exp_q[i].seq); else n_pass++;
            n_checks++; if (obs_frames[i].data !== exp_q[i].data) $display("[TB] FAIL rand_data%0d: got %h expected %h", i, obs_frames[i].data, exp_q[i].data); else n_pass++;
        end
    endtask

    task automatic test_reset_mid_frame();
        bit seen = 0;
        frame_ready_in = 1'b1; channel_mask = 16'h00FF;
        for (int i = 0; i < 3; i++) send(i, DW'(16'h3000 + i));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_seq = 8'd0;
        n_checks++; if (frame_valid_out !== 1'b0) $display("[TB] FAIL midrst_valid: got %0b expected 0", frame_valid_out); else n_pass++;
        n_checks++; if (frame_mask_out !== '0) $display("[TB] FAIL midrst_mask: got %h expected 0", frame_mask_out); else n_pass++;
        n_checks++; if (frame_data_out !== '0) $display("[TB] FAIL midrst_data: got %h expected 0", frame_data_out); else n_pass++;
        n_checks++; if (frame_seq_out !== 8'd0) $display("[TB] FAIL midrst_seq: got %0d expected 0", frame_seq_out); else n_pass++;
        n_checks++; if (drop_count !== '0) $display("[TB] FAIL midrst_drop: got %0d expected 0", drop_count); else n_pass++;
        repeat (TO + 8) begin
            tick();
            if (frame_valid_out) seen = 1;
        end
        n_checks++; if (seen !== 1'b0) $display("[TB] FAIL midrst_no_frame: got %0b expected 0", seen); else n_pass++;
        for (int i = 0; i < 8; i++) send(i, DW'(16'h4000 + i));
        n_checks++; if (frame_valid_out !== 1'b1) $display("[TB] FAIL midrst_next_valid: got %0b expected 1", frame_valid_out); else n_pass++;
        n_checks++; if (frame_seq_out !== exp_seq) $display("[TB] FAIL midrst_next_seq: got %0d expected %0d", frame_seq_out, exp_seq); else n_pass++;
        n_checks++; if (frame_mask_out !== 16'h00FF) $display("[TB] FAIL midrst_next_mask: got %h expected 00ff", frame_mask_out); else n_pass++;
        n_checks++; if (slot_of(0) !== 16'h4000) $display("[TB] FAIL midrst_next_slot0: got %h expected 4000", slot_of(0)); else n_pass++;
        n_checks++; if (slot_of(7) !== 16'h4007) $display("[TB] FAIL midrst_next_slot7: got %h expected 4007", slot_of(7)); else n_pass++;
        tick();
    endtask

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_complete_frame();
        test_timeout();
        test_duplicate();
        test_backpressure();
        test_stray();
        test_random();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/neural_frame_assembler.md
Name: neural_frame_assembler

Overview:
Receive-side counterpart of the neural channel aggregator. Consumes the serialized per-channel sample stream (data, channel ID, valid) on sys_clk and reassembles it into one parallel frame of NUM_CHANNELS samples plus a received-channel mask. Sits between the aggregator output and the downstream spike-processing stage, which takes whole frames over a valid/ready handshake.

Parameters:
NUM_CHANNELS, 16, number of channel slots per frame
DATA_WIDTH, 16, bits per sample
CH_ID_WIDTH, 4, channel ID width; must satisfy 2**CH_ID_WIDTH >= NUM_CHANNELS
TIMEOUT_CYCLES, 64, idle cycles in COLLECT before a partial frame is closed
DROP_CNT_WIDTH, 8, width of the saturating dropped-sample counter

Ports:
sys_clk  input  1  single clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
channel_mask  input  NUM_CHANNELS  expected channels; sampled at frame start
adc_data_in  input  DATA_WIDTH  serialized sample
adc_channel_in  input  CH_ID_WIDTH  channel ID of sample
adc_valid_in  input  1  sample qualifier; no backpressure to source
frame_data_out  output  NUM_CHANNELS*DATA_WIDTH  slot i at bits [i*DATA_WIDTH +: DATA_WIDTH]
frame_mask_out  output  NUM_CHANNELS  channels actually received this frame
frame_partial_out  output  1  frame closed before mask was complete
frame_seq_out  output  8  frame sequence number, wraps 255->0
frame_valid_out  output  1  frame available
frame_ready_in  input  1  downstream accepts frame
stray_err  output  1  one-cycle pulse: sample for channel not in the active mask, or ID >= NUM_CHANNELS
drop_count  output  DROP_CNT_WIDTH  saturating count of samples dropped while holding

Behaviour:
- Reset (rst=1 at clock edge): state IDLE; frame_data_out, frame_mask_out, frame_partial_out, frame_seq_out, frame_valid_out, stray_err, drop_count all 0; internal active mask and timeout counter 0. Reset mid-frame discards the partial frame. It is not emitted.
- FSM: IDLE, COLLECT, HOLD.
- IDLE: the first valid sample whose ID is in channel_mask does the following:
  - latch channel_mask as active mask
  - clear all slots and the received mask
  - write the sample and set its received bit
  - go to COLLECT, or to HOLD if this completes the mask (single-channel mask)
- IDLE: a sample not in channel_mask pulses stray_err and is discarded. With channel_mask==0, every sample is stray.
- COLLECT, each valid sample:
  - ID out of range or not in active mask: stray_err pulse, ignored.
  - Bit not yet received: store, set bit, clear timeout counter.
  - Bit already received (duplicate, meaning the next sweep has started): close the current frame with partial=1 and go to HOLD. The duplicate sample is held in a one-entry pending register and starts the next frame when HOLD exits.
- COLLECT: received mask == active mask goes to HOLD with partial=0.
- COLLECT timeout: counter increments on cycles with no accepted sample. At TIMEOUT_CYCLES it goes to HOLD with partial=1.
- Latency: frame_valid_out rises the cycle after the completing sample is clocked in. Frame outputs are registered and stable throughout HOLD.
- HOLD: frame_valid_out=1. Transfer occurs on frame_valid_out && frame_ready_in.
  - On transfer, frame_seq_out increments after the transfer and the FSM leaves HOLD next cycle.
  - If the pending register is full, the pending sample starts a new frame (COLLECT, active mask re-latched from channel_mask). Otherwise the FSM returns to IDLE.
  - A valid sample in the transfer cycle is processed as if in IDLE. It starts the new frame, or if pending is occupied it lands in the new frame's slot in the same cycle, since the pending entry and the new sample are in-mask and distinct.
- HOLD with no transfer: every valid sample is dropped and drop_count increments, saturating at all-ones. drop_count clears only on reset.
- frame_valid_out never deasserts without a transfer, except on reset.
- stray_err and a frame-close event in the same cycle are independent. Both occur.

Test Plan:
1. Complete frame: channel_mask=16'h00FF; ch0..7 with data 16'h1000+i on consecutive cycles; ready=1. Expected:
   - frame_valid_out one cycle after ch7, for 1 cycle
   - slots 0..7 = 1000..1007, slots 8..15 = 0
   - frame_mask_out=00FF, partial=0, seq=0; seq=1 afterwards
2. Timeout: mask=FFFF; ch0..4 sent, then idle. Expected: frame_valid_out 64 cycles after ch4 with frame_mask_out=001F and partial=1.
3. Duplicate: mask=000F; send ch0=AAAA, ch1=BBBB, then ch1=CCCC. Expected:
   - frame 1: mask 0003, partial=1, slot1=BBBB
   - after transfer, ch2, ch3, ch0 sent; frame 2 has slot1=CCCC, mask 000F, partial=0
4. Backpressure: ready=0; complete mask=0003 frame; send 3 more samples. Expected:
   - drop_count=3
   - frame outputs unchanged across HOLD
   - raising ready transfers exactly once and returns to IDLE
5. Stray: mask=0005; send ch1, then ch15 with NUM_CHANNELS=16 and mask bit clear. Expected: two stray_err pulses, state stays IDLE, no frame.
6. Reset mid-COLLECT: rst=1 for 1 cycle after 3 of 8 samples. Expected: all outputs 0, no frame emitted, next complete frame has seq=0.
